cc_serial_sorter: RTL and testbench
===================================

Name: cc_serial_sorter

Overview:
Sequential companion to the combinational CC compute core. It streams in four operands serially over a valid/ready handshake and sorts them in place with an odd-even transposition network. It then streams the sorted operands back out, one per cycle. It fills the serial-input and serial-output side of the operand interface that CC consumes in parallel.

Parameters:
DATA_W, 4, operand width in bits; N is fixed at 4 operands per frame

Ports:
clk        input   1        system clock, all state updates on rising edge
rst        input   1        synchronous reset, active-high
in_valid   input   1        operand beat valid
in_data    input   DATA_W   operand value
opt        input   2        frame option, sampled on first accepted beat; [0]=1 descending, 0 ascending; [1]=1 signed two's-complement compare, 0 unsigned
in_ready   output  1        block can accept a beat this cycle
out_valid  output  1        sorted operand valid this cycle
out_data   output  DATA_W   sorted operand value

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst. Sampled at a rising edge, rst forces state IDLE, clears the beat and phase counters, zeroes buf[0..3] and opt_q, and overrides any handshake in that cycle.
- Reset values: in_ready=1, out_valid=0, out_data=0.
- States are IDLE, LOAD, SORT and OUT. in_ready is 1 in IDLE and LOAD, 0 otherwise.
- Accept: a beat is accepted when in_valid && in_ready. Beat k (0..3) writes buf[k].
- First beat: the first accepted beat also captures opt into opt_q and moves IDLE->LOAD.
- in_valid gaps: allowed during LOAD; the state holds and the beat counter holds.
- Ignored beats: in_valid while in_ready=0 is ignored and has no side effects.
- End of load: the 4th accepted beat moves the state to SORT and clears the phase counter.
- SORT runs exactly 4 cycles.
  - Phases 0 and 2 compare-swap pairs (0,1) and (2,3).
  - Phases 1 and 3 compare-swap pair (1,2).
- Swap rule: for ascending order, swap when buf[i] > buf[i+1]; for descending order, swap when buf[i] < buf[i+1]. Use a signed compare when opt_q[1]=1. Equal values never swap.
- After phase 3, move to OUT.
- OUT runs exactly 4 consecutive cycles with out_valid=1 and out_data=buf[j], j=0..3. There is no backpressure.
- After j=3 the state returns to IDLE and in_ready=1 next cycle.
- Data outside OUT: out_data=0 whenever out_valid=0.
- Latency: if the 4th beat is accepted in cycle T, SORT occupies T+1..T+4 and out_valid is high in T+5..T+8. A new frame's first beat can be accepted in T+9.
- No arithmetic widening: values pass through unchanged, DATA_W bits.
- Reset mid-operation (LOAD, SORT or OUT): the frame is discarded, no further out_valid is produced, and the next cycle behaves as post-reset.

Decomposition:
- Shared package cc_pkg holds:
  - state enum {IDLE, LOAD, SORT, OUT};
  - constant N=4;
  - phase and beat counter width 2;
  - opt bit-position constants OPT_DESC=0 and OPT_SIGNED=1.
- One sub-module: cc_cmp_swap, a combinational compare-exchange on (a, b, desc, signed) producing (lo_pos, hi_pos).
  - Instantiate it 2x for pairs (0,1) and (2,3); reuse the (0,1) instance for pair (1,2) via a phase-selected mux, or instantiate it 3x.

Test Plan:
- Ascending, unsigned: opt=00, beats 3,9,0,9 back-to-back -> out_valid for 4 cycles starting 5 cycles after the last beat, out_data 0,3,9,9.
- Descending, signed: opt=11, beats 4'h7,4'h8,4'hF,4'h1 -> out_data 4'h7,4'h1,4'hF,4'h8 (7,1,-1,-8).
- Gapped input: opt=01, beats 2,5,1,5 with in_valid low 2 cycles between each beat -> out_data 5,5,2,1. Also drive in_valid high with junk during SORT/OUT; it is ignored and output is unchanged.
- Reset mid-SORT: load 4,3,2,1, assert rst in the 2nd SORT cycle -> out_valid never rises. Then in_ready=1 and a fresh frame 1,1,1,1 returns 1,1,1,1.
- Back-to-back frames: start the second frame's first beat in the cycle in_ready returns to 1 (T+9) -> accepted. Second frame opt=00 with 15,0,8,7 -> 0,7,8,15, and opt_q of frame 1 does not leak into frame 2.
- Already-sorted and reverse input under both orders: 0,1,2,3 and 3,2,1,0 with opt=00 and opt=01 -> correct order after exactly 4 SORT cycles.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and constants for the CC serial sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Operands per frame; the beat and phase counters span exactly 0..N-1.
    localparam int N     = 4;
    localparam int CNT_W = 2;

    // Bit positions inside the frame option word.
    localparam int OPT_DESC   = 0;
    localparam int OPT_SIGNED = 1;

endpackage

// File: rtl/cc_cmp_swap.sv
// Compare-exchange of one operand pair; lo_pos feeds slot i, hi_pos feeds slot i+1.
// Latency: combinational.
// Backpressure: none.
// Ports: a/b operands in slot order, desc selects descending order,
//        sgn selects two's-complement compare, lo_pos/hi_pos ordered result.
module cc_cmp_swap #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              desc,
    input  logic              sgn,
    output logic [DATA_W-1:0] lo_pos,
    output logic [DATA_W-1:0] hi_pos
);

    logic a_gt_b;
    logic a_lt_b;
    logic swap;

    always_comb begin
        if (sgn) begin
            a_gt_b = $signed(a) > $signed(b);
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_gt_b = a > b;
            a_lt_b = a < b;
        end
        // Equal operands fail both strict compares, so they never swap.
        swap   = desc ? a_lt_b : a_gt_b;
        lo_pos = swap ? b : a;
        hi_pos = swap ? a : b;
    end

endmodule

// File: rtl/cc_serial_sorter.sv
// Serial 4-operand sorter: load 4 beats, odd-even transposition sort, stream out.
// Latency: 4th beat accepted in T -> SORT T+1..T+4, out_valid T+5..T+8, ready again T+9.
// Backpressure: in_ready low during SORT and OUT; output side has no backpressure.
// Ports: clk/rst (sync, active-high), in_valid/in_data/opt beat input with
//        in_ready, out_valid/out_data sorted output stream (out_data is 0 when idle).
module cc_serial_sorter
    import cc_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        opt,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  beat_cnt;
    // Counts SORT phases, then is reused as the output index during OUT.
    logic [CNT_W-1:0]  phase_cnt;
    logic [DATA_W-1:0] buf_q [N];
    logic [1:0]        opt_q;
    logic              accept;

    logic [DATA_W-1:0] lo01, hi01, lo23, hi23, lo12, hi12;

    cc_cmp_swap #(.DATA_W(DATA_W)) u_cs01 (
        .a      (buf_q[0]),
        .b      (buf_q[1]),
        .desc   (opt_q[OPT_DESC]),
        .sgn    (opt_q[OPT_SIGNED]),
        .lo_pos (lo01),
        .hi_pos (hi01)
    );

    cc_cmp_swap #(.DATA_W(DATA_W)) u_cs23 (
        .a      (buf_q[2]),
        .b      (buf_q[3]),
        .desc   (opt_q[OPT_DESC]),
        .sgn    (opt_q[OPT_SIGNED]),
        .lo_pos (lo23),
        .hi_pos (hi23)
    );

    cc_cmp_swap #(.DATA_W(DATA_W)) u_cs12 (
        .a      (buf_q[1]),
        .b      (buf_q[2]),
        .desc   (opt_q[OPT_DESC]),
        .sgn    (opt_q[OPT_SIGNED]),
        .lo_pos (lo12),
        .hi_pos (hi12)
    );

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: if (accept && (beat_cnt == CNT_W'(N - 1))) state_d = SORT;
            SORT: if (phase_cnt == CNT_W'(N - 1)) state_d = OUT;
            OUT:  if (phase_cnt == CNT_W'(N - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            phase_cnt <= '0;
            opt_q     <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        buf_q[beat_cnt] <= in_data;
                        // Counter wraps to 0 on the 4th beat, ready for the next frame.
                        beat_cnt        <= beat_cnt + CNT_W'(1);
                        if (state_q == IDLE) begin
                            opt_q <= opt;
                        end
                        if (beat_cnt == CNT_W'(N - 1)) begin
                            phase_cnt <= '0;
                        end
                    end
                end
                SORT: begin
                    // Even phases exchange (0,1),(2,3); odd phases exchange (1,2).
                    if (!phase_cnt[0]) begin
                        buf_q[0] <= lo01;
                        buf_q[1] <= hi01;
                        buf_q[2] <= lo23;
                        buf_q[3] <= hi23;
                    end else begin
                        buf_q[1] <= lo12;
                        buf_q[2] <= hi12;
                    end
                    // Wraps to 0 after phase 3 so OUT starts at index 0.
                    phase_cnt <= phase_cnt + CNT_W'(1);
                end
                OUT: begin
                    phase_cnt <= phase_cnt + CNT_W'(1);
                end
                default: begin
                    phase_cnt <= '0;
                end
            endcase
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? buf_q[phase_cnt] : '0;

endmodule

// File: tb/tb_cc_serial_sorter.sv
module tb_cc_serial_sorter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic [1:0] opt;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    cc_serial_sorter #(.DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .opt       (opt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        opt      = 2'b00;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b out_data=%h, expected 1 0 0",
                     in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out_data=%h, expected 1 0 0",
                     in_ready, out_valid, out_data);
        end
    endtask

    // Drives one frame starting in the current cycle and checks the full
    // SORT/OUT timeline; returns in cycle T+9 with in_valid low.
    // Beats 1..3 drive the inverted option to show opt is only taken on beat 0.
    task automatic run_frame(input string name, input logic [1:0] o,
                             input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3,
                             input int gap, input bit junk,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] d [4];
        logic [3:0] e [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            opt      = (k == 0) ? o : ~o;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s in_ready beat %0d: got %b expected 1", name, k, in_ready);
            end
            step();
            in_valid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    n_checks++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s gap hold: in_ready=%b out_valid=%b expected 1 0",
                                 name, in_ready, out_valid);
                    end
                    step();
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 4'hA;
                opt      = 2'b10;
            end
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 4'h0) begin
                n_fail++;
                $display("FAIL %s sort cycle %0d: out_valid=%b in_ready=%b out_data=%h expected 0 0 0",
                         name, c, out_valid, in_ready, out_data);
            end
            step();
        end
        for (int j = 0; j < 4; j++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 4'h5;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e[j] || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s out beat %0d: out_valid=%b out_data=%h in_ready=%b expected 1 %h 0",
                         name, j, out_valid, out_data, in_ready, e[j]);
            end
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame end: out_valid=%b out_data=%h in_ready=%b expected 0 0 1",
                     name, out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_asc_unsigned;
        run_frame("asc_unsigned", 2'b00, 4'd3, 4'd9, 4'd0, 4'd9, 0, 1'b0,
                  4'd0, 4'd3, 4'd9, 4'd9);
    endtask

    task automatic test_desc_signed;
        run_frame("desc_signed", 2'b11, 4'h7, 4'h8, 4'hF, 4'h1, 0, 1'b0,
                  4'h7, 4'h1, 4'hF, 4'h8);
    endtask

    task automatic test_gapped_junk;
        run_frame("gapped_desc", 2'b01, 4'd2, 4'd5, 4'd1, 4'd5, 2, 1'b1,
                  4'd5, 4'd5, 4'd2, 4'd1);
    endtask

    task automatic test_reset_mid_sort;
        logic [3:0] d [4];
        bit         saw_valid;
        d[0] = 4'd4; d[1] = 4'd3; d[2] = 4'd2; d[3] = 4'd1;
        opt  = 2'b00;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            step();
        end
        in_valid = 1'b0;
        step();             // now in second SORT cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_sort after: in_ready=%b out_valid=%b out_data=%h expected 1 0 0",
                     in_ready, out_valid, out_data);
        end
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            step();
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sort no_output: saw out_valid=%b expected 0", saw_valid);
        end
        run_frame("after_reset", 2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 0, 1'b0,
                  4'd1, 4'd1, 4'd1, 4'd1);
    endtask

    task automatic test_back_to_back;
        run_frame("b2b_first", 2'b11, 4'h2, 4'hE, 4'h6, 4'h9, 0, 1'b0,
                  4'h6, 4'h2, 4'hE, 4'h9);
        // Starts in the cycle in_ready returns; a leaked signed compare
        // would give 8,F,0,7 instead.
        run_frame("b2b_second", 2'b00, 4'd15, 4'd0, 4'd8, 4'd7, 0, 1'b0,
                  4'd0, 4'd7, 4'd8, 4'd15);
    endtask

    task automatic test_sorted_reverse;
        run_frame("sorted_asc",   2'b00, 4'd0, 4'd1, 4'd2, 4'd3, 0, 1'b0,
                  4'd0, 4'd1, 4'd2, 4'd3);
        run_frame("sorted_desc",  2'b01, 4'd0, 4'd1, 4'd2, 4'd3, 0, 1'b0,
                  4'd3, 4'd2, 4'd1, 4'd0);
        run_frame("reverse_asc",  2'b00, 4'd3, 4'd2, 4'd1, 4'd0, 0, 1'b0,
                  4'd0, 4'd1, 4'd2, 4'd3);
        run_frame("reverse_desc", 2'b01, 4'd3, 4'd2, 4'd1, 4'd0, 0, 1'b0,
                  4'd3, 4'd2, 4'd1, 4'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        opt      = 2'b00;
        test_reset();
        test_asc_unsigned();
        test_desc_signed();
        test_gapped_junk();
        test_reset_mid_sort();
        test_back_to_back();
        test_sorted_reverse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
